// File: rtl/dram_pkg.sv
// Shared widths, line-address type and FSM states
// for the DRAM miss handler.
package dram_pkg;

    localparam int ADDR_W_DEF = 27;
    localparam int LINE_W_DEF = 128;

    typedef logic [ADDR_W_DEF-5:0] line_addr_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        RD,
        WAIT,
        FILL
    } state_t;

endpackage

// File: rtl/dram_miss_handler.sv
// Cache miss handler: optional victim write-back, line read, fill.
// Define MISS_WB_EN to enable dirty-victim write-back.
module dram_miss_handler
    import dram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [ADDR_W-5:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-5:0] evict_addr,
    input  logic [LINE_W-1:0] evict_data,
    output logic              fill_valid,
    output logic [ADDR_W-5:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [LINE_W-1:0] req_wdata,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    input  logic [LINE_W-1:0] rsp_data,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt
);

    state_t state;
    logic   wb_take;

`ifdef MISS_WB_EN
    logic [31:0] wb_cnt_q;
    assign wb_take = miss_dirty;
    assign wb_cnt  = wb_cnt_q;
`else
    logic unused_dirty;
    assign unused_dirty = miss_dirty;
    assign wb_take      = 1'b0;
    assign wb_cnt       = '0;
`endif

    assign miss_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            rsp_ready  <= 1'b0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            miss_cnt   <= '0;
`ifdef MISS_WB_EN
            wb_cnt_q   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_valid) begin
                        fill_addr <= miss_addr;
                        req_wdata <= evict_data;
                        req_valid <= 1'b1;
                        miss_cnt  <= miss_cnt + 32'd1;
                        if (wb_take) begin
                            state    <= WB;
                            req_we   <= 1'b1;
                            req_addr <= {evict_addr, 4'h0};
                        end else begin
                            state    <= RD;
                            req_we   <= 1'b0;
                            req_addr <= {miss_addr, 4'h0};
                        end
                    end
                end
                WB: begin
                    // request stays up; it retargets to the miss line
                    if (req_ready) begin
                        state    <= RD;
                        req_we   <= 1'b0;
                        req_addr <= {fill_addr, 4'h0};
`ifdef MISS_WB_EN
                        wb_cnt_q <= wb_cnt_q + 32'd1;
`endif
                    end
                end
                RD: begin
                    if (req_ready) begin
                        state     <= WAIT;
                        req_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        state      <= FILL;
                        rsp_ready  <= 1'b0;
                        fill_data  <= rsp_data;
                        fill_valid <= 1'b1;
                    end
                end
                FILL: begin
                    state      <= IDLE;
                    fill_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_miss_handler.sv
// Directed bench for dram_miss_handler; honours MISS_WB_EN
// so it matches whichever build it is compiled against.
module tb_dram_miss_handler;

    localparam int AW = 27;
    localparam int LW = 128;

`ifdef MISS_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          miss_valid;
    logic          miss_ready;
    logic [AW-5:0] miss_addr;
    logic          miss_dirty;
    logic [AW-5:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          fill_valid;
    logic [AW-5:0] fill_addr;
    logic [LW-1:0] fill_data;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [LW-1:0] rsp_data;
    logic [31:0]   miss_cnt;
    logic [31:0]   wb_cnt;

    dram_miss_handler #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .miss_valid (miss_valid),
        .miss_ready (miss_ready),
        .miss_addr  (miss_addr),
        .miss_dirty (miss_dirty),
        .evict_addr (evict_addr),
        .evict_data (evict_data),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-5:0] maddr;
        logic          dirty;
        logic [AW-5:0] eaddr;
        logic [LW-1:0] edata;
        int            dly;
        logic [LW-1:0] rdata;
    } vec_t;

    vec_t        vecs [4];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_miss = '0;
    logic [31:0] exp_wbc  = '0;
    int          wr_hs = 0;
    int          rsp_hs = 0;

    always @(posedge clk) begin
        if (req_valid && req_ready && req_we)
            wr_hs <= wr_hs + 1;
        if (rsp_valid && rsp_ready)
            rsp_hs <= rsp_hs + 1;
    end

    task automatic check(input string name,
                         input logic [LW-1:0] act,
                         input logic [LW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic do_miss(input vec_t v);
        bit wb;
        wb = v.dirty && WB_EN;
        check("idle_ready", miss_ready, 1);
        miss_valid = 1'b1;
        miss_addr  = v.maddr;
        miss_dirty = v.dirty;
        evict_addr = v.eaddr;
        evict_data = v.edata;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = ~v.maddr;
        evict_addr = ~v.eaddr;
        evict_data = ~v.edata;
        exp_miss   = exp_miss + 32'd1;
        check("busy_ready", miss_ready, 0);
        if (wb) begin
            check("wb_valid", req_valid, 1);
            check("wb_we", req_we, 1);
            check("wb_addr", req_addr, {v.eaddr, 4'h0});
            check("wb_wdata", req_wdata, v.edata);
            @(negedge clk);
            exp_wbc = exp_wbc + 32'd1;
        end
        check("rd_valid", req_valid, 1);
        check("rd_we", req_we, 0);
        check("rd_addr", req_addr, {v.maddr, 4'h0});
        @(negedge clk);
        check("wait_rsp_ready", rsp_ready, 1);
        check("wait_req_idle", req_valid, 0);
        repeat (v.dly) @(negedge clk);
        check("no_early_fill", fill_valid, 0);
        rsp_valid = 1'b1;
        rsp_data  = v.rdata;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_data  = '0;
        check("fill_valid", fill_valid, 1);
        check("fill_addr", fill_addr, v.maddr);
        check("fill_data", fill_data, v.rdata);
        check("fill_rsp_ready", rsp_ready, 0);
        check("fill_miss_ready", miss_ready, 0);
        @(negedge clk);
        check("fill_once", fill_valid, 0);
        check("back_idle", miss_ready, 1);
        check("miss_cnt", miss_cnt, exp_miss);
        check("wb_cnt", wb_cnt, exp_wbc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int          base;
        logic [LW-1:0] d;

        vecs[0] = '{23'h000010, 1'b0, 23'h0, '0,
                    5, {16{8'hA5}}};
        vecs[1] = '{23'h000030, 1'b1, 23'h000020,
                    {16{8'h3C}}, 2, {16{8'h5A}}};
        vecs[2] = '{23'h7FFFFF, 1'b1, 23'h7FFFFE,
                    {8{16'hBEEF}}, 0, {4{32'h1234_5678}}};
        vecs[3] = '{23'h000000, 1'b0, 23'h7FFFFF,
                    {16{8'hFF}}, 1, {16{8'h00}}};

        rstn       = 1'b0;
        miss_valid = 1'b0;
        miss_addr  = '0;
        miss_dirty = 1'b0;
        evict_addr = '0;
        evict_data = '0;
        req_ready  = 1'b1;
        rsp_valid  = 1'b0;
        rsp_data   = '0;
        repeat (2) @(negedge clk);
        check("rst_miss_ready", miss_ready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_rsp_ready", rsp_ready, 0);
        check("rst_fill_valid", fill_valid, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        check("rst_wb_cnt", wb_cnt, 0);
        check("rst_fill_data", fill_data, 0);
        check("rst_req_addr", req_addr, 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            do_miss(vecs[i]);

        // request held off for 7 cycles
        base       = wr_hs;
        req_ready  = 1'b0;
        miss_valid = 1'b1;
        miss_addr  = 23'h000066;
        miss_dirty = 1'b1;
        evict_addr = 23'h000055;
        evict_data = {4{32'hCAFE_F00D}};
        @(negedge clk);
        miss_valid = 1'b0;
        evict_data = '0;
        exp_miss   = exp_miss + 32'd1;
        for (int c = 0; c < 7; c++) begin
            check("stall_valid", req_valid, 1);
            check("stall_we", req_we, WB_EN);
            check("stall_addr", req_addr,
                  WB_EN ? {23'h000055, 4'h0}
                        : {23'h000066, 4'h0});
            if (WB_EN)
                check("stall_wdata", req_wdata,
                      {4{32'hCAFE_F00D}});
            @(negedge clk);
        end
        req_ready = 1'b1;
        @(negedge clk);
        if (WB_EN) begin
            exp_wbc = exp_wbc + 32'd1;
            check("stall_rd_addr", req_addr,
                  {23'h000066, 4'h0});
            @(negedge clk);
        end
        check("stall_wait", rsp_ready, 1);
        check("stall_wr_hs", wr_hs - base, WB_EN ? 1 : 0);
        rsp_valid = 1'b1;
        rsp_data  = {16{8'h77}};
        @(negedge clk);
        rsp_valid = 1'b0;
        check("stall_fill", fill_data, {16{8'h77}});
        @(negedge clk);
        check("stall_wb_cnt", wb_cnt, exp_wbc);

        // response offered before the read is granted
        base       = rsp_hs;
        d          = {8{16'h9A9A}};
        req_ready  = 1'b0;
        miss_valid = 1'b1;
        miss_addr  = 23'h000077;
        miss_dirty = 1'b0;
        @(negedge clk);
        miss_valid = 1'b0;
        exp_miss   = exp_miss + 32'd1;
        rsp_valid  = 1'b1;
        rsp_data   = d;
        repeat (3) begin
            @(negedge clk);
            check("stray_rsp_ready", rsp_ready, 0);
            check("stray_in_rd", req_valid, 1);
        end
        check("stray_unconsumed", rsp_hs - base, 0);
        req_ready = 1'b1;
        @(negedge clk);
        check("stray_wait", rsp_ready, 1);
        @(negedge clk);
        rsp_valid = 1'b0;
        check("stray_fill", fill_valid, 1);
        check("stray_data", fill_data, d);
        check("stray_taken", rsp_hs - base, 1);
        @(negedge clk);

        // counter wrap
        force dut.miss_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.miss_cnt;
        check("force_cnt", miss_cnt, 32'hFFFF_FFFF);
        exp_miss = 32'hFFFF_FFFF;
        do_miss(vecs[0]);
        check("wrap_cnt", miss_cnt, 0);

        // reset in WAIT, checked between clock edges
        miss_valid = 1'b1;
        miss_addr  = 23'h000012;
        miss_dirty = 1'b0;
        @(negedge clk);
        miss_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_wait", rsp_ready, 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_rsp_ready", rsp_ready, 0);
        check("arst_miss_ready", miss_ready, 1);
        check("arst_req_valid", req_valid, 0);
        check("arst_fill_addr", fill_addr, 0);
        check("arst_miss_cnt", miss_cnt, 0);
        exp_miss = '0;
        exp_wbc  = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_miss(vecs[1]);

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
